sum_accumulator: RTL and testbench



---
 rtl/sum_accumulator.sv | 130 +++++++++++++
 tb/tb_sum_accumulator.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// Accumulates COUNT consecutive 17-bit adder results into one saturated frame
// total, presented on a valid/ready output port that is held until accepted.
module sum_accumulator #(
    parameter int COUNT = 4,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_sum,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_sat
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [7:0]       LAST_CNT = 8'(COUNT - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

    // Saturating add: MSB of the result is the overflow flag, low bits the clamped sum.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W:0]   b);
        logic [ACC_W:0] raw;
        raw = {1'b0, a} + b;
        if (raw[ACC_W]) begin
            sat_add = {1'b1, ACC_MAX};
        end else begin
            sat_add = {1'b0, raw[ACC_W-1:0]};
        end
    endfunction

    state_t           state_r, state_nxt_s;
    logic [ACC_W-1:0] acc_r, acc_nxt_s;
    logic [7:0]       cnt_r, cnt_nxt_s;
    logic             sat_r, sat_nxt_s;
    logic [ACC_W-1:0] out_acc_r, out_acc_nxt_s;
    logic             out_sat_r, out_sat_nxt_s;
    logic [ACC_W:0]   operand_s;
    logic [ACC_W:0]   sum_s;

    assign operand_s = {{(ACC_W - 16){1'b0}}, in_cout, in_sum};
    assign sum_s     = sat_add(acc_r, operand_s);

    // Handshake flags come straight from the state register; clear blocks acceptance.
    assign in_ready  = (state_r == ACCUM) && !clear;
    assign out_valid = (state_r == HOLD);
    assign out_acc   = out_acc_r;
    assign out_sat   = out_sat_r;

    // Next-state and datapath update for the frame FSM.
    always_comb begin
        state_nxt_s   = state_r;
        acc_nxt_s     = acc_r;
        cnt_nxt_s     = cnt_r;
        sat_nxt_s     = sat_r;
        out_acc_nxt_s = out_acc_r;
        out_sat_nxt_s = out_sat_r;
        case (state_r)
            ACCUM: begin
                if (clear) begin
                    acc_nxt_s = ACC_ZERO;
                    cnt_nxt_s = 8'd0;
                    sat_nxt_s = 1'b0;
                end else if (in_valid) begin
                    if (cnt_r == LAST_CNT) begin
                        out_acc_nxt_s = sum_s[ACC_W-1:0];
                        out_sat_nxt_s = sat_r | sum_s[ACC_W];
                        state_nxt_s   = HOLD;
                        acc_nxt_s     = ACC_ZERO;
                        cnt_nxt_s     = 8'd0;
                        sat_nxt_s     = 1'b0;
                    end else begin
                        acc_nxt_s = sum_s[ACC_W-1:0];
                        sat_nxt_s = sat_r | sum_s[ACC_W];
                        cnt_nxt_s = cnt_r + 8'd1;
                    end
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            HOLD: begin
                // A cleared frame is discarded, so its total is not left visible.
                if (clear) begin
                    state_nxt_s   = ACCUM;
                    out_acc_nxt_s = ACC_ZERO;
                    out_sat_nxt_s = 1'b0;
                end else if (out_ready) begin
                    state_nxt_s = ACCUM;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = ACCUM;
                acc_nxt_s   = ACC_ZERO;
                cnt_nxt_s   = 8'd0;
                sat_nxt_s   = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ACCUM;
            acc_r     <= ACC_ZERO;
            cnt_r     <= 8'd0;
            sat_r     <= 1'b0;
            out_acc_r <= ACC_ZERO;
            out_sat_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            acc_r     <= acc_nxt_s;
            cnt_r     <= cnt_nxt_s;
            sat_r     <= sat_nxt_s;
            out_acc_r <= out_acc_nxt_s;
            out_sat_r <= out_sat_nxt_s;
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed table-driven bench for sum_accumulator; two instances (ACC_W=24 and
// ACC_W=18) share one stimulus stream so saturation is seen on the narrow one.
module tb_sum_accumulator;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [15:0] in_sum;
    logic        in_cout;
    logic        out_ready;

    logic        ir_a, ov_a, sat_a;
    logic [23:0] acc_a;
    logic        ir_b, ov_b, sat_b;
    logic [17:0] acc_b;

    int n_cmp;
    int n_bad;
    int row_idx;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        valid;
        logic        ordy;
        logic        clr;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_acc;
        logic        e_sat;
        logic [31:0] e_acc18;
        logic        e_sat18;
    } vec_t;

    vec_t vecs[$];

    sum_accumulator #(.COUNT(4), .ACC_W(24)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(ir_a), .in_sum(in_sum), .in_cout(in_cout),
        .out_valid(ov_a), .out_ready(out_ready), .out_acc(acc_a), .out_sat(sat_a)
    );

    sum_accumulator #(.COUNT(4), .ACC_W(18)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(ir_b), .in_sum(in_sum), .in_cout(in_cout),
        .out_valid(ov_b), .out_ready(out_ready), .out_acc(acc_b), .out_sat(sat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h expected %h", name, row_idx, act, exp);
        end
    endtask

    task automatic check_outputs(input logic eir, input logic eov,
                                 input logic [31:0] ea, input logic es,
                                 input logic [31:0] eb, input logic ebs);
        chk("in_ready24",  32'(ir_a),  32'(eir));
        chk("out_valid24", 32'(ov_a),  32'(eov));
        chk("out_acc24",   32'(acc_a), ea);
        chk("out_sat24",   32'(sat_a), 32'(es));
        chk("in_ready18",  32'(ir_b),  32'(eir));
        chk("out_valid18", 32'(ov_b),  32'(eov));
        chk("out_acc18",   32'(acc_b), eb);
        chk("out_sat18",   32'(sat_b), 32'(ebs));
    endtask

    task automatic row(input logic [15:0] s, input logic c, input logic v,
                       input logic r, input logic cl, input logic eir, input logic eov,
                       input logic [31:0] ea, input logic es,
                       input logic [31:0] eb, input logic ebs);
        vec_t t;
        t.sum = s; t.cout = c; t.valid = v; t.ordy = r; t.clr = cl;
        t.e_ir = eir; t.e_ov = eov; t.e_acc = ea; t.e_sat = es;
        t.e_acc18 = eb; t.e_sat18 = ebs;
        vecs.push_back(t);
    endtask

    // Four back-to-back accepted inputs; outputs still show the previous frame.
    task automatic frame4(input logic [15:0] s, input logic c,
                          input logic [31:0] pa, input logic ps,
                          input logic [31:0] pb, input logic pbs);
        for (int k = 0; k < 4; k++) begin
            row(s, c, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, pa, ps, pb, pbs);
        end
    endtask

    // Outputs are checked 1 ns after the inputs change, before the next rising edge.
    task automatic run_all();
        foreach (vecs[i]) begin
            @(negedge clk);
            in_sum    = vecs[i].sum;
            in_cout   = vecs[i].cout;
            in_valid  = vecs[i].valid;
            out_ready = vecs[i].ordy;
            clear     = vecs[i].clr;
            #1;
            check_outputs(vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_acc, vecs[i].e_sat,
                          vecs[i].e_acc18, vecs[i].e_sat18);
            row_idx++;
        end
        vecs.delete();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; row_idx = 0;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
        in_sum = 16'h0000; in_cout = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame 1+2+3+4.
        row(16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        row(16'h0002, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        row(16'h0003, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        row(16'h0004, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        row(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA, 1'b0, 32'hA, 1'b0);
        // Carry-out weighting; the 18-bit instance saturates.
        frame4(16'hFFFF, 1'b1, 32'hA, 1'b0, 32'hA, 1'b0);
        row(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h7FFFC, 1'b0, 32'h3FFFF, 1'b1);
        // Sticky flag clears for the next frame.
        frame4(16'h0001, 1'b0, 32'h7FFFC, 1'b0, 32'h3FFFF, 1'b1);
        row(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h4, 1'b0);
        // Gaps inside a frame, then 5 cycles of backpressure with in_valid held high.
        row(16'h0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 1'b0, 32'h4, 1'b0);
        row(16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 1'b0, 32'h4, 1'b0);
        row(16'h0020, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 1'b0, 32'h4, 1'b0);
        row(16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 1'b0, 32'h4, 1'b0);
        row(16'h0030, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 1'b0, 32'h4, 1'b0);
        row(16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 1'b0, 32'h4, 1'b0);
        row(16'h0040, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 1'b0, 32'h4, 1'b0);
        for (int k = 0; k < 5; k++) begin
            row(16'h0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0, 1'b0, 32'hA0, 1'b0);
        end
        row(16'h0100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA0, 1'b0, 32'hA0, 1'b0);
        // Nothing offered during HOLD may leak into this frame.
        frame4(16'h0001, 1'b0, 32'hA0, 1'b0, 32'hA0, 1'b0);
        row(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h4, 1'b0);
        // clear mid-frame drops the partial sum and the same-cycle input.
        row(16'h0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 1'b0, 32'h4, 1'b0);
        row(16'h0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 1'b0, 32'h4, 1'b0);
        row(16'h0010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4, 1'b0, 32'h4, 1'b0);
        frame4(16'h0001, 1'b0, 32'h4, 1'b0, 32'h4, 1'b0);
        row(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h4, 1'b0);
        // clear during HOLD discards the pending frame.
        frame4(16'h0002, 1'b0, 32'h4, 1'b0, 32'h4, 1'b0);
        row(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 1'b0, 32'h8, 1'b0);
        row(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8, 1'b0, 32'h8, 1'b0);
        row(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        frame4(16'h0007, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        run_all();

        // Async reset between edges while holding a 0x1C frame.
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
        #1;
        check_outputs(1'b0, 1'b1, 32'h1C, 1'b0, 32'h1C, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid24", 32'(ov_a), 32'h0);
        chk("rst_out_acc24",   32'(acc_a), 32'h0);
        chk("rst_out_valid18", 32'(ov_b), 32'h0);
        chk("rst_out_acc18",   32'(acc_b), 32'h0);
        #1 rst_n = 1'b1;
        frame4(16'h0005, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        row(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h14, 1'b0, 32'h14, 1'b0);
        row(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h14, 1'b0, 32'h14, 1'b0);
        run_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
